// File: rtl/pf_mem_arbiter_pkg.sv
// Shared types and address helpers for the instruction-side memory arbiter (package pf_pkg).
package pf_pkg;

  localparam int ICACHE_LINE_WIDTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP,
    DRAIN
  } arb_state_e;

  typedef enum logic {
    OWN_DMD,
    OWN_PF
  } owner_e;

  // Zero the line-offset bits of a byte address; callers cast back to their width.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int ofs);
    return (addr >> ofs) << ofs;
  endfunction

  function automatic logic [63:0] page_of(input logic [63:0] addr, input int page_bits);
    return addr >> page_bits;
  endfunction

endpackage

// File: rtl/pf_mem_arbiter_page_filter.sv
// Remembers the page of the last granted line and flags prefetches that would leave it.
module pf_page_filter
  import pf_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PAGE_BITS  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  upd_i,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_i,
  output logic                  cross_o
);

  localparam int PW = ADDR_WIDTH - PAGE_BITS;

  logic [PW-1:0] page_q;
  logic          page_valid_q;
  logic [PW-1:0] chk_page;

  assign chk_page = PW'(page_of(64'(chk_addr_i), PAGE_BITS));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      page_q       <= '0;
      page_valid_q <= 1'b0;
    end else begin
      if (upd_i) page_q <= PW'(page_of(64'(upd_addr_i), PAGE_BITS));
      // Flush wins: after a squash any page is acceptable again.
      if (flush_i)    page_valid_q <= 1'b0;
      else if (upd_i) page_valid_q <= 1'b1;
    end
  end

  assign cross_o = page_valid_q && (chk_page != page_q);

endmodule

// File: rtl/pf_mem_arbiter.sv
// Arbitrates the instruction memory port between demand refills and next-line prefetches.
// Optional starvation guard for prefetches: define PF_ARB_STARVE_GUARD_EN.
module pf_mem_arbiter
  import pf_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int CL_SIZE      = ICACHE_LINE_WIDTH,
  parameter int PAGE_BITS    = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  en_i,
  input  logic                  dmd_req_i,
  input  logic [ADDR_WIDTH-1:0] dmd_addr_i,
  output logic                  dmd_gnt_o,
  output logic                  dmd_rvalid_o,
  output logic [CL_SIZE-1:0]    dmd_rdata_o,
  input  logic                  pf_req_i,
  input  logic [ADDR_WIDTH-1:0] pf_addr_i,
  output logic                  pf_gnt_o,
  output logic                  pf_drop_o,
  output logic                  pf_rvalid_o,
  output logic [CL_SIZE-1:0]    pf_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [CL_SIZE-1:0]    mem_rdata_i,
  output logic                  busy_o
);

  localparam int OFS = $clog2(CL_SIZE / 8);

  // Handshake: a requester's gnt pulses in the IDLE cycle it is accepted; mem_req_o/mem_addr_o
  // stay stable until mem_gnt_i; exactly one mem_rvalid_i closes each accepted request.
  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  flush_seen_q, flush_seen_d;

  logic pf_pend;
  logic pf_cross;
  logic starve_hit;
  logic sel_pf;

  assign pf_pend = pf_req_i && en_i;
  assign sel_pf  = pf_pend && (!dmd_req_i || starve_hit);

`ifdef PF_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || !pf_pend || pf_gnt_o || pf_drop_o) begin
      starve_cnt_q <= '0;
    end else if (dmd_gnt_o && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
      starve_cnt_q <= starve_cnt_q + SW'(1);
    end
  end

  assign starve_hit = (starve_cnt_q == SW'(STARVE_LIMIT));
`else
  // Guard compiled out: demand always has strict priority.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  pf_page_filter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PAGE_BITS (PAGE_BITS)
  ) u_page_filter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .upd_i     (dmd_gnt_o || pf_gnt_o),
    .upd_addr_i(pf_gnt_o ? pf_addr_i : dmd_addr_i),
    .chk_addr_i(pf_addr_i),
    .cross_o   (pf_cross)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DMD;
      addr_q       <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    flush_seen_d = flush_seen_q;
    dmd_gnt_o    = 1'b0;
    pf_gnt_o     = 1'b0;
    pf_drop_o    = 1'b0;
    dmd_rvalid_o = 1'b0;
    pf_rvalid_o  = 1'b0;
    dmd_rdata_o  = '0;
    pf_rdata_o   = '0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (!flush_i) begin
            if (sel_pf) begin
              if (pf_cross) begin
                pf_drop_o = 1'b1;
              end else begin
                pf_gnt_o     = 1'b1;
                owner_d      = OWN_PF;
                addr_d       = ADDR_WIDTH'(line_align(64'(pf_addr_i), OFS));
                flush_seen_d = 1'b0;
                state_d      = WAIT_GNT;
              end
            end else if (dmd_req_i) begin
              dmd_gnt_o    = 1'b1;
              owner_d      = OWN_DMD;
              addr_d       = ADDR_WIDTH'(line_align(64'(dmd_addr_i), OFS));
              flush_seen_d = 1'b0;
              state_d      = WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          mem_req_o  = 1'b1;
          mem_addr_o = addr_q;
          if (flush_i) flush_seen_d = 1'b1;
          if (mem_gnt_i) state_d = (flush_seen_q || flush_i) ? DRAIN : WAIT_RSP;
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state_d = IDLE;
            if (!flush_i) begin
              if (owner_q == OWN_PF) begin
                pf_rvalid_o = 1'b1;
                pf_rdata_o  = mem_rdata_i;
              end else begin
                dmd_rvalid_o = 1'b1;
                dmd_rdata_o  = mem_rdata_i;
              end
            end
          end else if (flush_i) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o = !rst_i && (state_q != IDLE);

endmodule

// File: tb/tb_pf_mem_arbiter.sv
// Bench for pf_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_pf_mem_arbiter;

  localparam int AW    = 32;
  localparam int CLW   = 128;
  localparam int LIMIT = 4;
`ifdef PF_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i, flush_i, en_i;
  logic           dmd_req_i, pf_req_i, mem_gnt_i, mem_rvalid_i;
  logic [AW-1:0]  dmd_addr_i, pf_addr_i;
  logic [CLW-1:0] mem_rdata_i;
  logic           dmd_gnt_o, dmd_rvalid_o, pf_gnt_o, pf_drop_o, pf_rvalid_o;
  logic           mem_req_o, busy_o;
  logic [CLW-1:0] dmd_rdata_o, pf_rdata_o;
  logic [AW-1:0]  mem_addr_o;

  pf_mem_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .en_i        (en_i),
    .dmd_req_i   (dmd_req_i),
    .dmd_addr_i  (dmd_addr_i),
    .dmd_gnt_o   (dmd_gnt_o),
    .dmd_rvalid_o(dmd_rvalid_o),
    .dmd_rdata_o (dmd_rdata_o),
    .pf_req_i    (pf_req_i),
    .pf_addr_i   (pf_addr_i),
    .pf_gnt_o    (pf_gnt_o),
    .pf_drop_o   (pf_drop_o),
    .pf_rvalid_o (pf_rvalid_o),
    .pf_rdata_o  (pf_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_busy, m_acc, m_squash, m_pf, m_page_ok;
  logic [AW-1:0] m_addr;
  logic [19:0]   m_page;
  int            m_streak;
  logic [AW-1:0] exp_q[$];

  // sampled DUT outputs of the last step, for directed checks
  logic           s_dgnt, s_pgnt, s_drop, s_drv, s_prv, s_mreq, s_busy;
  logic [AW-1:0]  s_maddr;
  logic [CLW-1:0] s_drd, s_prd;
  bit             gnt_order[$];

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    bit             e_dgnt, e_pgnt, e_drop, e_drv, e_prv, e_mreq, e_busy, pend, take_pf;
    logic [AW-1:0]  e_maddr, acc_addr;
    logic [CLW-1:0] e_drd, e_prd;
    #1;
    {e_dgnt, e_pgnt, e_drop, e_drv, e_prv, e_mreq, e_busy} = '0;
    e_maddr = '0; e_drd = '0; e_prd = '0;
    pend = pf_req_i && en_i;
    if (!rst_i) begin
      e_busy = m_busy;
      if (!m_busy && !flush_i) begin
        take_pf = pend && (!dmd_req_i || (GUARD && m_streak == LIMIT));
        if (take_pf) begin
          if (m_page_ok && pf_addr_i[31:12] != m_page) e_drop = 1'b1;
          else e_pgnt = 1'b1;
        end else begin
          e_dgnt = dmd_req_i;
        end
      end
      if (m_busy && !m_acc) begin
        e_mreq  = 1'b1;
        e_maddr = m_addr;
      end
      if (m_busy && m_acc && mem_rvalid_i && !m_squash && !flush_i) begin
        if (m_pf) begin e_prv = 1'b1; e_prd = mem_rdata_i; end
        else      begin e_drv = 1'b1; e_drd = mem_rdata_i; end
      end
    end

    s_dgnt = dmd_gnt_o; s_pgnt = pf_gnt_o; s_drop = pf_drop_o; s_drv = dmd_rvalid_o;
    s_prv = pf_rvalid_o; s_mreq = mem_req_o; s_busy = busy_o; s_maddr = mem_addr_o;
    s_drd = dmd_rdata_o; s_prd = pf_rdata_o;
    if (s_dgnt) gnt_order.push_back(1'b0);
    if (s_pgnt) gnt_order.push_back(1'b1);

    check("dmd_gnt", 128'(s_dgnt), 128'(e_dgnt));
    check("pf_gnt", 128'(s_pgnt), 128'(e_pgnt));
    check("pf_drop", 128'(s_drop), 128'(e_drop));
    check("mem_req", 128'(s_mreq), 128'(e_mreq));
    check("mem_addr", 128'(s_maddr), 128'(e_maddr));
    check("dmd_rvalid", 128'(s_drv), 128'(e_drv));
    check("dmd_rdata", s_drd, e_drd);
    check("pf_rvalid", 128'(s_prv), 128'(e_prv));
    check("pf_rdata", s_prd, e_prd);
    check("busy", 128'(s_busy), 128'(e_busy));

    // scoreboard: address of each line handed to memory, in acceptance order
    if (s_mreq && mem_gnt_i && !rst_i) begin
      acc_addr = exp_q.size() > 0 ? exp_q.pop_front() : '1;
      check("sb_addr", 128'(s_maddr), 128'(acc_addr));
    end

    if (rst_i) begin
      {m_busy, m_acc, m_squash, m_pf, m_page_ok} = '0;
      m_streak = 0;
      exp_q.delete();
    end else begin
      if (flush_i || !pend || e_pgnt || e_drop) m_streak = 0;
      else if (e_dgnt && m_streak < LIMIT) m_streak++;
      if (e_dgnt || e_pgnt) begin
        acc_addr  = e_pgnt ? pf_addr_i : dmd_addr_i;
        m_busy    = 1'b1; m_acc = 1'b0; m_squash = 1'b0; m_pf = e_pgnt;
        m_addr    = {acc_addr[31:4], 4'h0};
        m_page    = acc_addr[31:12];
        m_page_ok = 1'b1;
        exp_q.push_back(m_addr);
      end else if (m_busy && !m_acc) begin
        if (flush_i) m_squash = 1'b1;
        if (mem_gnt_i) m_acc = 1'b1;
      end else if (m_busy) begin
        if (mem_rvalid_i) m_busy = 1'b0;
        else if (flush_i) m_squash = 1'b1;
      end
      if (flush_i) m_page_ok = 1'b0;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic g, input logic r);
    mem_gnt_i    = g;
    mem_rvalid_i = r;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic demand(input logic [AW-1:0] a);
    dmd_req_i  = 1'b1;
    dmd_addr_i = a;
    step();
    dmd_req_i  = 1'b0;
  endtask

  function automatic logic [CLW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [CLW-1:0] A5 = {32{4'hA, 4'h5}};

  initial begin
    {rst_i, flush_i, en_i, dmd_req_i, pf_req_i, mem_gnt_i, mem_rvalid_i} = 7'b1000000;
    dmd_addr_i = '0; pf_addr_i = '0; mem_rdata_i = '0;
    m_streak = 0;
    @(negedge clk_i);
    step(); step();
    check("rst_busy", 128'(s_busy), 128'(0));
    rst_i = 1'b0;
    en_i  = 1'b1;
    step();

    // demand only
    demand(32'h8000_1234);
    check("t1_gnt", 128'(s_dgnt), 128'(1));
    cyc(0, 0);
    check("t1_addr", 128'(s_maddr), 128'(32'h8000_1230));
    cyc(1, 0);
    mem_rdata_i = A5;
    cyc(0, 0); cyc(0, 0); cyc(0, 1);
    check("t1_rvalid", 128'(s_drv), 128'(1));
    check("t1_rdata", s_drd, A5);
    check("t1_pf_rvalid", 128'(s_prv), 128'(0));

    // both requesting on the same page: demand first, then prefetch
    pf_req_i = 1'b1; pf_addr_i = 32'h8000_1240;
    demand(32'h8000_1100);
    check("t2_dmd_first", 128'(s_dgnt), 128'(1));
    check("t2_pf_wait", 128'(s_pgnt), 128'(0));
    cyc(1, 0); cyc(0, 1);
    step();
    check("t2_pf_gnt", 128'(s_pgnt), 128'(1));
    pf_req_i = 1'b0;
    cyc(0, 0);
    check("t2_pf_addr", 128'(s_maddr), 128'(32'h8000_1240));
    mem_rdata_i = rand_line();
    cyc(1, 0); cyc(0, 1);
    check("t2_pf_rvalid", 128'(s_prv), 128'(1));

    // page crossing prefetch dropped
    demand(32'h8000_1FF0);
    cyc(1, 0); cyc(0, 1);
    pf_req_i = 1'b1; pf_addr_i = 32'h8000_2000;
    step();
    check("t3_drop", 128'(s_drop), 128'(1));
    check("t3_no_gnt", 128'(s_pgnt), 128'(0));
    pf_req_i = 1'b0;
    step();
    check("t3_no_req", 128'(s_mreq), 128'(0));

    // flush while waiting for the response
    demand(32'h8000_1F00);
    cyc(1, 0);
    flush_i = 1'b1; cyc(0, 0); flush_i = 1'b0;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    cyc(0, 1);
    check("t4_no_drv", 128'(s_drv), 128'(0));
    check("t4_busy_hold", 128'(s_busy), 128'(1));
    pf_req_i = 1'b1; pf_addr_i = 32'h8000_2000;
    step();
    check("t4_busy_fall", 128'(s_busy), 128'(0));
    check("t4_pf_ok", 128'(s_pgnt), 128'(1));
    pf_req_i = 1'b0;
    cyc(1, 0); cyc(0, 1);

    // flush while waiting for the memory grant
    demand(32'h8000_1300);
    flush_i = 1'b1; cyc(0, 0); flush_i = 1'b0;
    cyc(0, 0);
    check("t5_req_held", 128'(s_mreq), 128'(1));
    cyc(1, 0); cyc(0, 1);
    check("t5_no_drv", 128'(s_drv), 128'(0));

`ifdef PF_ARB_STARVE_GUARD_EN
    gnt_order.delete();
    dmd_req_i = 1'b1; dmd_addr_i = 32'h8000_1000;
    pf_req_i  = 1'b1; pf_addr_i  = 32'h8000_1040;
    for (int t = 0; t < 6; t++) begin
      step(); cyc(1, 0);
      dmd_req_i = 1'b1;
      cyc(0, 1);
    end
    dmd_req_i = 1'b0; pf_req_i = 1'b0;
    check("starve_count", 128'(gnt_order.size()), 128'(6));
    for (int t = 0; t < 6 && t < gnt_order.size(); t++)
      check("starve_order", 128'(gnt_order[t]), 128'(t == 4));
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst_i        = ($urandom_range(0, 199) == 0);
      flush_i      = ($urandom_range(0, 24) == 0);
      en_i         = ($urandom_range(0, 4) != 0);
      dmd_req_i    = $urandom_range(0, 1);
      pf_req_i     = $urandom_range(0, 1);
      dmd_addr_i   = {20'h80000 | 20'($urandom_range(1, 3)), 12'($urandom)};
      pf_addr_i    = {20'h80000 | 20'($urandom_range(1, 2)), 12'($urandom)};
      mem_gnt_i    = ($urandom_range(0, 2) == 0);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = rand_line();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pf_mem_arbiter.md
Name: pf_mem_arbiter

Overview:
- Sequences the single instruction-side memory port between two requesters:
  - demand line refills from the instruction cache;
  - next-line prefetches from the stream buffer.
- One outstanding transaction at a time. Responses are routed back to the owner.
- Prefetches that cross the current page are filtered out.
- On flush, any in-flight response is drained so no stale line reaches either requester.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- CL_SIZE, ICACHE_LINE_WIDTH, line width in bits. Line offset bits OFS = $clog2(CL_SIZE/8).
- PAGE_BITS, 12, page offset width used by the page-crossing filter.
- STARVE_LIMIT, 4, consecutive demand grants before a pending prefetch is forced through (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  squash all activity
- en_i  in  1  prefetch enable
- dmd_req_i  in  1  demand refill request
- dmd_addr_i  in  ADDR_WIDTH  demand miss address
- dmd_gnt_o  out  1  demand accepted strobe
- dmd_rvalid_o  out  1  demand line valid
- dmd_rdata_o  out  CL_SIZE  demand line
- pf_req_i  in  1  prefetch request
- pf_addr_i  in  ADDR_WIDTH  prefetch address
- pf_gnt_o  out  1  prefetch accepted strobe
- pf_drop_o  out  1  prefetch rejected (page crossing)
- pf_rvalid_o  out  1  prefetch line valid
- pf_rdata_o  out  CL_SIZE  prefetch line
- mem_req_o  out  1  memory request, held until granted
- mem_addr_o  out  ADDR_WIDTH  line-aligned address
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  CL_SIZE  memory response line
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_i is synchronous and active-high.
  - On reset: state=IDLE; owner, page_valid and starve counter cleared; all outputs 0.
  - Reset mid-transaction abandons the transaction with no drain; the memory side is reset alongside.
- FSM states: IDLE, WAIT_GNT, WAIT_RSP, DRAIN.
- IDLE arbitration, evaluated only when flush_i=0:
  - Demand wins by default.
  - Prefetch is eligible only if en_i=1.
  - Page filter: if an eligible prefetch is selected, page_valid=1 and pf_addr_i[ADDR_WIDTH-1:PAGE_BITS] != page_q, then pf_drop_o=1 for that cycle, no grant, state stays IDLE.
  - Otherwise the winner's gnt_o pulses combinationally. Address (low OFS bits zeroed) and owner are latched; page_q/page_valid are updated; next state is WAIT_GNT.
- WAIT_GNT:
  - mem_req_o=1 and mem_addr_o=latched address, both stable until mem_gnt_i.
  - On mem_gnt_i: go to WAIT_RSP, or DRAIN if flush_i was seen since acceptance (sticky flag).
- WAIT_RSP:
  - mem_rvalid_i forwards combinationally to the owner: owner rvalid=1, rdata=mem_rdata_i, same cycle. Next state IDLE.
  - Non-owner rvalid stays 0; rdata outputs are 0 when not valid.
  - flush_i without rvalid goes to DRAIN.
  - flush_i together with rvalid: response suppressed, next state IDLE.
- DRAIN:
  - mem_rvalid_i is swallowed (no rvalid to either side), then IDLE.
- Throughput: one bubble cycle (IDLE) between transactions. Minimum turnaround is accept, gnt, rvalid = 3 cycles.
- flush_i:
  - In IDLE: no grants, page_valid cleared.
  - In any state: page_valid cleared.
- en_i=0: pf_gnt_o=0 and pf_drop_o=0; demand is unaffected.
- mem_rvalid_i in IDLE or WAIT_GNT is ignored.
- mem_gnt_i outside WAIT_GNT is ignored.

Optional Feature:
- Macro: PF_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter ($clog2(STARVE_LIMIT+1) bits) increments on each demand grant while pf_req_i&&en_i is pending, and saturates.
  - When counter==STARVE_LIMIT and both requests are present in IDLE, the prefetch wins (still subject to the page filter).
  - The counter clears on any prefetch grant or drop, on flush or reset, and on any cycle where the prefetch is not pending.
- Undefined: strict demand priority, no counter logic, STARVE_LIMIT unused.

Decomposition:
- Shared package pf_pkg holds:
  - arb_state_e (IDLE, WAIT_GNT, WAIT_RSP, DRAIN);
  - owner_e (OWN_DMD, OWN_PF);
  - line_align() function;
  - page_of() function.
- One natural sub-module: pf_page_filter, a combinational compare plus registered page_q/page_valid. Everything else stays in the top.

Test Plan:
- Demand only: dmd_req_i with addr 0x8000_1234, gnt after 2 cycles, rvalid after 3 more → mem_addr_o=0x8000_1230 (CL_SIZE=128); dmd_rvalid_o with data 0xA5..; pf outputs 0.
- Both requesting in IDLE with page_q=0x80001 and pf_addr 0x8000_1240 → dmd wins. After that transaction the pf is granted with mem_addr_o=0x8000_1240.
- Page crossing: after demand 0x8000_1FF0, pf_addr 0x8000_2000 → pf_drop_o pulses one cycle, no mem_req_o.
- Flush in WAIT_RSP, rvalid 4 cycles later → neither rvalid asserted, busy_o falls the cycle after rvalid. Next pf to 0x8000_2000 is accepted because page_valid was cleared.
- Flush in WAIT_GNT → mem_req_o held until gnt, response drained, no rvalid out.
- With PF_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: continuous dmd_req_i and pf_req_i on the same page → grant order D,D,D,D,P,D…
